// File: rtl/argmax_tree_pipe_if.sv
// Handshake bundle for the argmax tree: Q-value beat in, (max, index) result out.
interface argmax_tree_pipe_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHANNELS    = 4,
  parameter int INDEX_WIDTH = $clog2(CHANNELS)
);
  logic                           i_valid;
  logic                           i_ready;
  logic [DATA_WIDTH*CHANNELS-1:0] i_data;
  logic                           o_valid;
  logic                           o_ready;
  logic [DATA_WIDTH-1:0]          o_data;
  logic [INDEX_WIDTH-1:0]         o_index;

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_data, o_index
  );

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_data, o_index
  );
endinterface

// File: rtl/argmax_tree_pipe.sv
// Pipelined max/argmax reduction tree, one register stage per tree level,
// with a single global stall driven by the output handshake.
module argmax_tree_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHANNELS    = 4,
  parameter bit SIGNED_CMP  = 1'b1,
  parameter int INDEX_WIDTH = $clog2(CHANNELS),
  parameter int LEVELS      = $clog2(CHANNELS)
) (
  input logic               clk,
  input logic               rst_n,
  argmax_tree_pipe_if.slave bus
);
  localparam int P = 1 << LEVELS;
  localparam int H = P / 2;
  localparam logic [DATA_WIDTH-1:0] PAD_VAL =
    SIGNED_CMP ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : '0;

  logic [DATA_WIDTH-1:0]  w_cv  [LEVELS][P];
  logic [INDEX_WIDTH-1:0] w_ci  [LEVELS][P];
  logic [DATA_WIDTH-1:0]  w_nv  [LEVELS][H];
  logic [INDEX_WIDTH-1:0] w_ni  [LEVELS][H];
  logic [DATA_WIDTH-1:0]  r_val [LEVELS][H];
  logic [INDEX_WIDTH-1:0] r_idx [LEVELS][H];
  logic [LEVELS-1:0]      r_vld;
  logic                   w_advance;

  function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                              input logic [DATA_WIDTH-1:0] b);
    if (SIGNED_CMP) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Candidates for each level: padded input for level 0, previous stage otherwise
  always_comb begin
    for (int k = 0; k < LEVELS; k++) begin
      for (int j = 0; j < P; j++) begin
        w_cv[k][j] = '0;
        w_ci[k][j] = '0;
      end
    end
    for (int j = 0; j < CHANNELS; j++) begin
      w_cv[0][j] = bus.i_data[j*DATA_WIDTH +: DATA_WIDTH];
      w_ci[0][j] = INDEX_WIDTH'(j);
    end
    for (int j = CHANNELS; j < P; j++) begin
      w_cv[0][j] = PAD_VAL;
      w_ci[0][j] = INDEX_WIDTH'(j);
    end
    for (int k = 1; k < LEVELS; k++) begin
      for (int j = 0; j < H; j++) begin
        w_cv[k][j] = r_val[k-1][j];
        w_ci[k][j] = r_idx[k-1][j];
      end
    end
  end

  // Right element wins only when strictly greater, so ties keep the lower index
  always_comb begin
    for (int k = 0; k < LEVELS; k++) begin
      for (int j = 0; j < H; j++) begin
        w_nv[k][j] = w_cv[k][2*j];
        w_ni[k][j] = w_ci[k][2*j];
        if (gt(w_cv[k][2*j+1], w_cv[k][2*j])) begin
          w_nv[k][j] = w_cv[k][2*j+1];
          w_ni[k][j] = w_ci[k][2*j+1];
        end
      end
    end
  end

  assign w_advance   = !r_vld[LEVELS-1] || bus.o_ready;
  assign bus.i_ready = w_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < LEVELS; k++) begin
        for (int j = 0; j < H; j++) begin
          r_val[k][j] <= '0;
          r_idx[k][j] <= '0;
        end
      end
    end else if (w_advance) begin
      r_vld[0] <= bus.i_valid;
      for (int k = 1; k < LEVELS; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
      for (int k = 0; k < LEVELS; k++) begin
        for (int j = 0; j < H; j++) begin
          r_val[k][j] <= w_nv[k][j];
          r_idx[k][j] <= w_ni[k][j];
        end
      end
    end
  end

  assign bus.o_valid = r_vld[LEVELS-1];
  assign bus.o_data  = r_vld[LEVELS-1] ? r_val[LEVELS-1][0] : '0;
  assign bus.o_index = r_vld[LEVELS-1] ? r_idx[LEVELS-1][0] : '0;
endmodule
